adc_capture_buffer: RTL and testbench
=====================================

// Module: adc_capture_buffer
// PURPOSE
//  Parametrised single-clock capture buffer between the LVDS capture stage and the USB read-out.
//  Packs NCH channels of DW-bit samples into one frame per dclk and stores it in a DEPTH-frame circular RAM.
//  Two modes: free-run FIFO, or triggered capture with a programmable pre-trigger window.
//  Drains through a valid/ready stream and flags completion on rdy.
// PARAMETERS
//  NCH    4     channels per frame
//  DW     16    bits per sample
//  DEPTH  1024  frames stored; power of 2, >=4
//  AW     $clog2(DEPTH)  address width (derived, not overridden)
// PORTS
//  dclk      in   1        sample clock; all logic on rising edge
//  mr        in   1        master reset, asynchronous, active LOW
//  din       in   NCH*DW   frame; channel k in din[k*DW +: DW]
//  din_vld   in   1        frame on din is valid this cycle
//  wen       in   1        write/arm enable, active LOW, level
//  mode      in   1        0 = free-run FIFO, 1 = triggered
//  trig      in   1        trigger, rising edge detected internally
//  pre_cnt   in   AW       frames kept before trigger (triggered mode)
//  rd_ready  in   1        consumer accepts dout
//  dout      out  NCH*DW   head frame
//  dout_vld  out  1        dout holds a valid frame
//  rdy       out  1        triggered capture complete, data ready to drain
//  ovf       out  1        sticky: a valid frame was dropped
//  level     out  AW+1     frames stored, including the output register
// BEHAVIOUR
//  Reset (mr=0): pointers=0, level=0, dout=0, dout_vld=0, rdy=0, ovf=0, state=IDLE; RAM contents not cleared.
//  Write: frame accepted when din_vld & ~wen & write-allowed; RAM write at edge N; visible on dout/dout_vld after edge N+2 if the buffer was empty.
//  Read: show-ahead; a transfer occurs when dout_vld & rd_ready. The next frame is on dout the following cycle when level>1.
//  full = (level==DEPTH). A write while full is accepted only if a transfer happens in the same cycle; otherwise the frame is dropped and ovf is set.
//  ovf clears only on reset or in IDLE when wen is deasserted.
//  Simultaneous write and transfer: level is unchanged. Pointers wrap modulo DEPTH.
//  mode and pre_cnt are sampled only when leaving IDLE; changes after that are ignored until IDLE is re-entered.
//  FSM:
//   IDLE : ~wen -> FREE if mode=0, PRE if mode=1.
//   FREE : plain FIFO; wen=1 stops writes but keeps data; returns to IDLE when wen=1 & level=0.
//   PRE  : write frames; when level==pre_cnt -> ARM (pre_cnt=0 -> ARM immediately).
//   ARM  : each write also discards the oldest frame, so level stays at pre_cnt; dout_vld is held 0.
//          A trig rising edge -> POST; the trigger-cycle frame is the first post-trigger frame.
//   POST : write until level==DEPTH -> DONE; dout_vld is held 0; ovf cannot set.
//   DONE : rdy=1; writes blocked; drain via rd_ready; level=0 -> rdy=0, state IDLE.
//  wen=1 in PRE/ARM/POST aborts the capture: flush (level=0), state IDLE, rdy stays 0.
//  wen=1 in DONE does not abort; the buffer keeps draining.
//  trig edge in PRE is ignored; the edge detector keeps its last trig value through all states.
//  Triggered result: exactly DEPTH frames, pre_cnt before the trigger frame, oldest first.
// CONFIGURATION
//  TEST_PATTERN_EN defined: adds input tp_en (1 bit).
//   When tp_en=1, the stored frame replaces din: channel k = ramp + k, where ramp is a DW-bit counter
//   that increments on each accepted frame, wraps at 2^DW, and resets to 0.
//   din_vld still gates writes.
//  TEST_PATTERN_EN undefined: no tp_en port, no ramp logic; din is stored unchanged.
// TESTING
//  Reset: mr=0 mid-POST with level=500 -> all outputs at reset values next cycle, asynchronously; state IDLE.
//  Free-run, DEPTH=16: write 20 frames with rd_ready=0 -> level=16, ovf=1, dout = frame 0.
//   Then rd_ready=1 -> frames 0..15 out in order, no gaps.
//  Full plus simultaneous transfer: level=16, din_vld=1, rd_ready=1 -> frame accepted, level stays 16, ovf stays 0.
//  Triggered, DEPTH=16, pre_cnt=4, ramp data 0,1,2..., trig on frame 37 ->
//   rdy=1 after 12 post-trigger frames; drained sequence 33..48.
//  Abort: wen=1 during POST -> level=0, state IDLE, rdy=0; re-arm works normally.
//  TEST_PATTERN_EN, NCH=4, DW=8, tp_en=1: 300 frames -> frame n = {n+3,n+2,n+1,n} mod 256 per channel.

Source files
------------

// File: rtl/adc_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module  : adc_capture_buffer_if
//  Brief   : Stream/control bundle between the LVDS capture stage, the
//            capture buffer and the USB read-out. The producer side drives
//            frames and controls; the buffer side returns the head frame
//            and status.
//  Options : TEST_PATTERN_EN adds the tp_en control line.
//  Rev     : 1.0  initial release
// ============================================================================
interface adc_capture_buffer_if #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic [NCH*DW-1:0] din;
    logic              din_vld;
    logic              wen;
    logic              mode;
    logic              trig;
    logic [AW-1:0]     pre_cnt;
    logic              rd_ready;
    logic [NCH*DW-1:0] dout;
    logic              dout_vld;
    logic              rdy;
    logic              ovf;
    logic [AW:0]       level;
`ifdef TEST_PATTERN_EN
    logic              tp_en;
`endif

    modport master (
`ifdef TEST_PATTERN_EN
        output tp_en,
`endif
        output din, din_vld, wen, mode, trig, pre_cnt, rd_ready,
        input  dout, dout_vld, rdy, ovf, level
    );

    modport slave (
`ifdef TEST_PATTERN_EN
        input  tp_en,
`endif
        input  din, din_vld, wen, mode, trig, pre_cnt, rd_ready,
        output dout, dout_vld, rdy, ovf, level
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : adc_capture_buffer
//  Brief   : Single-clock capture buffer. Packs NCH x DW-bit samples into a
//            frame per dclk and keeps up to DEPTH frames in a circular RAM.
//            Free-run FIFO mode, or triggered capture with a programmable
//            pre-trigger window. Show-ahead valid/ready drain.
//  Options : TEST_PATTERN_EN replaces stored data with a per-channel ramp
//            when tp_en is high.
//  Rev     : 1.0  initial release
// ============================================================================
module adc_capture_buffer #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 1024
) (
    input logic                 dclk,
    input logic                 mr,
    adc_capture_buffer_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          FW       = NCH * DW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FREE = 3'd1,
        S_PRE  = 3'd2,
        S_ARM  = 3'd3,
        S_POST = 3'd4,
        S_DONE = 3'd5
    } state_t;

    logic [FW-1:0] mem [DEPTH];

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] pre_cnt_q,  pre_cnt_d;
    logic [AW:0]   level_q,    level_d;
    logic [FW-1:0] dout_q,     dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          rdy_q,      rdy_d;
    logic          ovf_q,      ovf_d;
    logic          trig_q,     trig_d;
    logic          acc_dly_q,  acc_dly_d;

    logic          frame_in;
    logic          xfer;
    logic          trig_rise;
    logic          full;
    logic          acc;
    logic          pop;
    logic          flush;
    logic [FW-1:0] wdata;

`ifdef TEST_PATTERN_EN
    logic [DW-1:0] ramp_q, ramp_d;
    logic [FW-1:0] tp_frame;

    for (genvar k = 0; k < NCH; k++) begin : g_tp_ch
        assign tp_frame[k*DW +: DW] = ramp_q + DW'(k);
    end

    assign ramp_d = ramp_q + DW'(acc);
    assign wdata  = bus.tp_en ? tp_frame : bus.din;
`else
    assign wdata  = bus.din;
`endif

    // Next-state logic: decide accept/pop for this cycle, then the FSM move.
    // The head frame keeps its RAM slot until popped, so level counts the
    // output register too. A frame accepted at the last edge is not yet
    // readable through the output register, hence acc_dly_q in dout_vld_d.
    always_comb begin
        frame_in  = bus.din_vld & ~bus.wen;
        xfer      = dout_vld_q & bus.rd_ready;
        trig_rise = bus.trig & ~trig_q;
        full      = (level_q == FULL_LVL);
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        ovf_d     = ovf_q;
        acc       = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.wen) begin
                    state_d   = bus.mode ? S_PRE : S_FREE;
                    pre_cnt_d = bus.pre_cnt;
                end else begin
                    ovf_d = 1'b0;
                end
            end
            S_FREE: begin
                pop = xfer;
                acc = frame_in & (~full | xfer);
                if (frame_in & full & ~xfer) begin
                    ovf_d = 1'b1;
                end
                if (bus.wen && (level_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (bus.wen) begin
                    flush = 1'b1;
                end else begin
                    acc = frame_in & (level_q < {1'b0, pre_cnt_q});
                end
            end
            S_ARM: begin
                // Sliding window: a non-trigger frame replaces the oldest.
                // With an empty window only the trigger frame is kept.
                if (bus.wen) begin
                    flush = 1'b1;
                end else begin
                    acc = frame_in & (trig_rise | (pre_cnt_q != '0));
                    pop = acc & ~trig_rise;
                end
            end
            S_POST: begin
                if (bus.wen) begin
                    flush = 1'b1;
                end else begin
                    acc = frame_in & ~full;
                end
            end
            S_DONE: begin
                pop = xfer;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d  = wr_ptr_q + AW'(acc);
        rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
        level_d   = flush ? '0 : level_q + (AW+1)'(acc) - (AW+1)'(pop);
        acc_dly_d = acc;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_PRE:   if (level_d == {1'b0, pre_cnt_q}) state_d = S_ARM;
                S_ARM:   if (trig_rise) state_d = (level_d == FULL_LVL) ? S_DONE : S_POST;
                S_POST:  if (level_d == FULL_LVL) state_d = S_DONE;
                S_DONE:  if (level_d == '0) state_d = S_IDLE;
                default: ;
            endcase
        end

        // Triggered data is released only once the capture is complete.
        rdy_d      = (state_d == S_DONE);
        dout_vld_d = ((state_d == S_FREE) || (state_d == S_DONE)) &&
                     ((level_q - (AW+1)'(acc_dly_q)) > (AW+1)'(pop));
        dout_d     = mem[rd_ptr_d];
        trig_d     = bus.trig;
    end

    // Frame storage; contents survive reset.
    always_ff @(posedge dclk) begin
        if (acc) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // All control state and registered outputs.
    always_ff @(posedge dclk or negedge mr) begin
        if (!mr) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pre_cnt_q  <= '0;
            level_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            ovf_q      <= 1'b0;
            trig_q     <= 1'b0;
            acc_dly_q  <= 1'b0;
`ifdef TEST_PATTERN_EN
            ramp_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pre_cnt_q  <= pre_cnt_d;
            level_q    <= level_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            rdy_q      <= rdy_d;
            ovf_q      <= ovf_d;
            trig_q     <= trig_d;
            acc_dly_q  <= acc_dly_d;
`ifdef TEST_PATTERN_EN
            ramp_q     <= ramp_d;
`endif
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.rdy      = rdy_q;
    assign bus.ovf      = ovf_q;
    assign bus.level    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adc_capture_buffer
//  Brief   : Directed bench for adc_capture_buffer (DEPTH=16, NCH=4, DW=8).
//            Expected frames are queued as they are driven and compared
//            against dout on every valid/ready transfer.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_adc_capture_buffer;
    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int FW    = NCH * DW;

    logic dclk = 1'b0;
    logic mr   = 1'b0;
    always #5 dclk = ~dclk;

    adc_capture_buffer_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

    adc_capture_buffer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .dclk (dclk),
        .mr   (mr),
        .bus  (bus)
    );

    logic [FW-1:0] sb [$];
    logic [FW-1:0] exp_f;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Frame n carries n+k on channel k (mod 2^DW).
    function automatic logic [FW-1:0] mk(input int n);
        logic [FW-1:0] f;
        for (int k = 0; k < NCH; k++) f[k*DW +: DW] = DW'(n + k);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic frame(input logic [FW-1:0] f);
        bus.din     = f;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
    endtask

    task automatic drain();
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: a transfer happens at the coming edge when valid & ready.
    always @(negedge dclk) begin
        if (mr && bus.dout_vld && bus.rd_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 64'(bus.dout_vld), 64'd0);
            end else begin
                exp_f = sb.pop_front();
                chk("dout_order", 64'(bus.dout), 64'(exp_f));
            end
        end
    end

    initial begin
        bus.din      = '0;
        bus.din_vld  = 1'b0;
        bus.wen      = 1'b1;
        bus.mode     = 1'b0;
        bus.trig     = 1'b0;
        bus.pre_cnt  = '0;
        bus.rd_ready = 1'b0;
`ifdef TEST_PATTERN_EN
        bus.tp_en    = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_level",    64'(bus.level),    64'd0);
        chk("rst_dout",     64'(bus.dout),     64'd0);
        chk("rst_dout_vld", 64'(bus.dout_vld), 64'd0);
        chk("rst_rdy",      64'(bus.rdy),      64'd0);
        chk("rst_ovf",      64'(bus.ovf),      64'd0);
        mr = 1'b1;
        tick();

        // Free-run: overfill then drain with no gaps.
        bus.wen = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) sb.push_back(mk(i));
            frame(mk(i));
        end
        tick(); tick();
        chk("free_full_level", 64'(bus.level),    64'd16);
        chk("free_ovf",        64'(bus.ovf),      64'd1);
        chk("free_head",       64'(bus.dout),     64'(mk(0)));
        chk("free_head_vld",   64'(bus.dout_vld), 64'd1);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("no_gap_vld", 64'(bus.dout_vld), 64'd1);
            tick();
        end
        chk("free_empty_level", 64'(bus.level),    64'd0);
        chk("free_empty_vld",   64'(bus.dout_vld), 64'd0);
        chk("free_sb_empty",    64'(sb.size()),    64'd0);

        // ovf clears in IDLE with wen high.
        bus.rd_ready = 1'b0;
        bus.wen = 1'b1;
        tick(); tick();
        chk("ovf_clear", 64'(bus.ovf), 64'd0);

        // Full plus simultaneous transfer.
        bus.wen = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            sb.push_back(mk(50 + i));
            frame(mk(50 + i));
        end
        tick(); tick();
        chk("full2_level", 64'(bus.level), 64'd16);
        sb.push_back(mk(66));
        bus.rd_ready = 1'b1;
        frame(mk(66));
        bus.rd_ready = 1'b0;
        chk("full_xfer_level", 64'(bus.level), 64'd16);
        chk("full_xfer_ovf",   64'(bus.ovf),   64'd0);
        drain();
        chk("full_drained_level", 64'(bus.level), 64'd0);

        // Triggered capture, pre_cnt=4, trigger on frame 37.
        bus.rd_ready = 1'b0;
        bus.wen = 1'b1;
        tick(); tick();
        bus.mode    = 1'b1;
        bus.pre_cnt = 4'd4;
        bus.wen     = 1'b0;
        tick();
        bus.pre_cnt = 4'd9;
        bus.mode    = 1'b0;
        for (int n = 0; n <= 48; n++) begin
            if (n >= 33) sb.push_back(mk(n));
            bus.trig = (n >= 37 && n < 42);
            if (n == 20) chk("arm_level", 64'(bus.level), 64'd4);
            if (n == 40) chk("post_vld_held", 64'(bus.dout_vld), 64'd0);
            if (n == 48) chk("rdy_before_last", 64'(bus.rdy), 64'd0);
            frame(mk(n));
        end
        bus.trig = 1'b0;
        chk("trig_rdy",   64'(bus.rdy),   64'd1);
        chk("trig_level", 64'(bus.level), 64'd16);
        frame(mk(99));
        chk("done_blocks_write", 64'(bus.level), 64'd16);
        drain();
        chk("done_rdy_clear", 64'(bus.rdy),   64'd0);
        chk("done_level",     64'(bus.level), 64'd0);

        // Abort during POST, then re-arm.
        bus.rd_ready = 1'b0;
        bus.wen = 1'b1;
        tick(); tick();
        bus.mode    = 1'b1;
        bus.pre_cnt = 4'd2;
        bus.wen     = 1'b0;
        tick();
        for (int n = 0; n < 8; n++) begin
            bus.trig = (n == 3);
            frame(mk(200 + n));
        end
        bus.trig = 1'b0;
        chk("post_level", 64'(bus.level), 64'd7);
        bus.wen = 1'b1;
        tick();
        chk("abort_level", 64'(bus.level),    64'd0);
        chk("abort_rdy",   64'(bus.rdy),      64'd0);
        chk("abort_vld",   64'(bus.dout_vld), 64'd0);
        bus.wen = 1'b0;
        tick();
        for (int m = 0; m <= 18; m++) begin
            if (m >= 3) sb.push_back(mk(300 + m));
            bus.trig = (m == 5);
            frame(mk(300 + m));
        end
        bus.trig = 1'b0;
        chk("rearm_rdy", 64'(bus.rdy), 64'd1);
        drain();
        chk("rearm_rdy_clear", 64'(bus.rdy), 64'd0);

        // Asynchronous reset mid-POST, then first-write latency.
        bus.rd_ready = 1'b0;
        bus.wen = 1'b1;
        tick(); tick();
        bus.mode    = 1'b1;
        bus.pre_cnt = 4'd2;
        bus.wen     = 1'b0;
        tick();
        for (int n = 0; n < 10; n++) begin
            bus.trig = (n == 2);
            frame(mk(n));
        end
        bus.trig = 1'b0;
        chk("pre_reset_level", 64'(bus.level), 64'd10);
        #2;
        mr = 1'b0;
        #1;
        chk("arst_level",    64'(bus.level),    64'd0);
        chk("arst_dout",     64'(bus.dout),     64'd0);
        chk("arst_dout_vld", 64'(bus.dout_vld), 64'd0);
        chk("arst_rdy",      64'(bus.rdy),      64'd0);
        chk("arst_ovf",      64'(bus.ovf),      64'd0);
        tick();
        mr = 1'b1;
        bus.mode = 1'b0;
        tick();
        bus.rd_ready = 1'b1;
        sb.push_back(mk(77));
        frame(mk(77));
        chk("lat_n0", 64'(bus.dout_vld), 64'd0);
        tick();
        chk("lat_n1", 64'(bus.dout_vld), 64'd0);
        tick();
        chk("lat_n2",      64'(bus.dout_vld), 64'd1);
        chk("lat_n2_data", 64'(bus.dout),     64'(mk(77)));
        tick();
        chk("lat_sb_empty", 64'(sb.size()), 64'd0);

`ifdef TEST_PATTERN_EN
        // Ramp pattern from reset: frame n = {n+3,n+2,n+1,n}.
        bus.rd_ready = 1'b0;
        bus.wen = 1'b1;
        mr = 1'b0;
        tick();
        mr = 1'b1;
        bus.tp_en = 1'b1;
        bus.wen   = 1'b0;
        tick();
        bus.rd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sb.push_back(mk(n));
            frame(FW'($urandom));
        end
        drain();
        bus.tp_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
